// File: rtl/div_seq_32bit_pkg.sv
// Shared definitions for the sequential restoring divider:
// state encoding, default widths and the divide-by-zero quotient.
package div_seq_32bit_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = 6;

    // Quotient produced when the divisor is zero.
    localparam logic [DIV_W-1:0] DIV_Q_DBZ = '1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_seq_32bit_if.sv
// Request/response bundle between the EX stage and the divider.
// The master issues start with operands; the slave answers with busy/done
// and holds the results until the next operation completes.
interface div_seq_32bit_if #(
    parameter int WIDTH = div_seq_32bit_pkg::DIV_W
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_seq_32bit_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_step_32bit
    import div_seq_32bit_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             quo_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             quo_bit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;

    // Shift, trial subtract, and select restored or reduced remainder.
    // The partial remainder stays below 2^WIDTH, so the shifted value never
    // sets its top bit and trial's top bit is a clean borrow flag.
    always_comb begin
        shifted   = {rem_i, quo_msb_i};
        trial     = shifted - {2'b00, divisor_i};
        borrow    = trial[WIDTH+1];
        quo_bit_o = ~borrow;
        rem_o     = borrow ? shifted[WIDTH:0] : trial[WIDTH:0];
    end

endmodule

// File: rtl/div_seq_32bit.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Fixed latency: start accepted at edge N gives done after edge N+WIDTH+1.
// Optional build macro DIV_SIGNED_EN selects two's-complement operands
// (magnitudes divided, signs applied when the results are registered).
module div_seq_32bit
    import div_seq_32bit_pkg::*;
#(
    parameter int WIDTH = DIV_W,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    div_seq_32bit_if.slave     div_if
);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic [WIDTH:0]   step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] load_dvd;
    logic [WIDTH-1:0] load_dvs;

`ifdef DIV_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    // Operand magnitudes; the most negative value maps onto itself, which
    // is the correct unsigned magnitude.
    always_comb begin
        load_dvd = div_if.dividend[WIDTH-1] ? -div_if.dividend : div_if.dividend;
        load_dvs = div_if.divisor[WIDTH-1]  ? -div_if.divisor  : div_if.divisor;
    end
`else
    // Unsigned operands load unchanged.
    always_comb begin
        load_dvd = div_if.dividend;
        load_dvs = div_if.divisor;
    end
`endif

    div_step_32bit #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .quo_msb_i (quo_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_bit_o (step_bit)
    );

    // Next-state and datapath control for IDLE -> CALC -> DONE.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (div_if.start) begin
                    quo_d   = load_dvd;
                    dvs_d   = load_dvs;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
`ifdef DIV_SIGNED_EN
                    neg_quo_d = div_if.dividend[WIDTH-1] ^ div_if.divisor[WIDTH-1];
                    neg_rem_d = div_if.dividend[WIDTH-1];
`endif
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dbz_d   = (dvs_q == '0);
                state_d = IDLE;
`ifdef DIV_SIGNED_EN
                // Divide by zero keeps the all-ones quotient regardless of
                // sign; the remainder magnitude is |dividend|, so re-signing
                // it restores the original dividend.
                if (dvs_q == '0) begin
                    quotient_d = DIV_Q_DBZ[WIDTH-1:0];
                end else begin
                    quotient_d = neg_quo_q ? -quo_q : quo_q;
                end
                remainder_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
`else
                quotient_d  = quo_q;
                remainder_d = rem_q[WIDTH-1:0];
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign div_if.busy        = busy_q;
    assign div_if.done        = done_q;
    assign div_if.div_by_zero = dbz_q;
    assign div_if.quotient    = quotient_q;
    assign div_if.remainder   = remainder_q;

endmodule
